// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit with wrap or signed-saturate modes.
// The carry chain is cut into STAGES equal segments behind a single global stall.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow
);

   localparam int SEG = WIDTH / STAGES;
   localparam int MSB = WIDTH - 1;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] cy_q, cy_d;
   logic [STAGES-1:0] sat_q, sat_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];

   logic             adv;
   logic [WIDTH-1:0] b_in;
   logic [SEG:0]     seg_sum;
   logic             a_sign;
   logic             b_sign;
   logic             r_sign;

   // b_q carries B' (already inverted for subtract); sum_q holds the finished low segments.
   always_comb begin
      adv      = !(valid_q[STAGES-1] && !out_ready);
      in_ready = adv;
      b_in     = op[0] ? ~in2 : in2;
      valid_d  = valid_q;
      cy_d     = cy_q;
      sat_d    = sat_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      seg_sum  = '0;
      if (adv) begin
         seg_sum    = {1'b0, in1[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, op[0]};
         valid_d[0] = in_valid;
         a_d[0]     = in1;
         b_d[0]     = b_in;
         sat_d[0]   = op[1];
         cy_d[0]    = seg_sum[SEG];
         sum_d[0]   = '0;
         sum_d[0][SEG-1:0] = seg_sum[SEG-1:0];
         for (int k = 1; k < STAGES; k++) begin
            seg_sum    = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                         + {{SEG{1'b0}}, cy_q[k-1]};
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            sat_d[k]   = sat_q[k-1];
            cy_d[k]    = seg_sum[SEG];
            sum_d[k]   = sum_q[k-1];
            sum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         cy_q    <= '0;
         sat_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cy_q    <= cy_d;
         sat_q   <= sat_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Overflow and the saturate mux only look at the last stage, so all-zero registers give zero outputs.
   always_comb begin
      out_valid = valid_q[STAGES-1];
      carry     = cy_q[STAGES-1];
      a_sign    = a_q[STAGES-1][MSB];
      b_sign    = b_q[STAGES-1][MSB];
      r_sign    = sum_q[STAGES-1][MSB];
      overflow  = (a_sign == b_sign) && (r_sign != a_sign);
      out       = sum_q[STAGES-1];
      if (sat_q[STAGES-1] && overflow) begin
         out = a_sign ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32/2 directed and backpressure tests,
// plus random streams on 8/4 and 32/1 instances against a full-width reference add.
module tb_pipelined_adder;

   typedef struct {
      logic [31:0] res;
      logic        cy;
      logic        ov;
      int          acc;
      bit          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t q_m[$];
   exp_t q8[$];
   exp_t q1[$];

   logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_carry, m_ovf;
   logic [31:0] m_in1, m_in2, m_out;
   logic [1:0]  m_op;
   logic        p8_in_valid, p8_in_ready, p8_out_valid, p8_out_ready, p8_carry, p8_ovf;
   logic [7:0]  p8_in1, p8_in2, p8_out;
   logic [1:0]  p8_op;
   logic        p1_in_valid, p1_in_ready, p1_out_valid, p1_out_ready, p1_carry, p1_ovf;
   logic [31:0] p1_in1, p1_in2, p1_out;
   logic [1:0]  p1_op;

   logic [31:0] sv_a   [10] = '{32'h3, 32'h5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h8000_0000, 32'h10, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] sv_b   [10] = '{32'h5, 32'h3, 32'h1, 32'h1, 32'h1,
                                32'h8000_0000, 32'h20, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
   logic [1:0]  sv_op  [10] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11};
   logic [31:0] sv_res [10] = '{32'hFFFF_FFFE, 32'h2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h8000_0000, 32'h30, 32'h0, 32'h1, 32'h8000_0000};
   logic        sv_cy  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic        sv_ov  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_adder #(.WIDTH(32), .STAGES(2)) dut_main (
      .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .in1(m_in1), .in2(m_in2), .op(m_op), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out(m_out), .carry(m_carry), .overflow(m_ovf));

   pipelined_adder #(.WIDTH(8), .STAGES(4)) dut_w8s4 (
      .clk(clk), .reset_n(reset_n), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
      .in1(p8_in1), .in2(p8_in2), .op(p8_op), .out_valid(p8_out_valid), .out_ready(p8_out_ready),
      .out(p8_out), .carry(p8_carry), .overflow(p8_ovf));

   pipelined_adder #(.WIDTH(32), .STAGES(1)) dut_w32s1 (
      .clk(clk), .reset_n(reset_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
      .in1(p1_in1), .in2(p1_in2), .op(p1_op), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
      .out(p1_out), .carry(p1_carry), .overflow(p1_ovf));

   function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op);
      exp_t        e;
      logic [31:0] mask, a_m, bp, raw;
      logic [63:0] full;
      logic        as, bs, rs;
      mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a_m   = a & mask;
      bp    = (op[0] ? ~b : b) & mask;
      full  = {32'd0, a_m} + {32'd0, bp} + {63'd0, op[0]};
      raw   = full[31:0] & mask;
      e.cy  = full[w];
      as    = a_m[w-1];
      bs    = bp[w-1];
      rs    = raw[w-1];
      e.ov  = (as == bs) && (rs != as);
      e.res = (op[1] && e.ov) ? (as ? (32'd1 << (w - 1)) : (mask >> 1)) : raw;
      e.acc = 0;
      e.lat = 1'b1;
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] res, input logic cy, input logic ov);
      exp_t e;
      e.res = res;
      e.cy  = cy;
      e.ov  = ov;
      e.acc = 0;
      e.lat = 1'b1;
      return e;
   endfunction

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 7))
         0: return 8'h00;
         1: return 8'h7F;
         2: return 8'h80;
         3: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard pops happen 1 time unit after the falling edge, when the handshake inputs have settled.
   always @(negedge clk) begin : mon_main
      exp_t e;
      #1;
      if (m_out_valid && m_out_ready) begin
         checks++;
         if (q_m.size() == 0) begin
            errors++;
            $display("[TB] FAIL main_unexpected: out=%h seen, required no beat", m_out);
         end else begin
            e = q_m.pop_front();
            if (m_out !== e.res) begin errors++; $display("[TB] FAIL main_out: got %h want %h", m_out, e.res); end
            checks++;
            if (m_carry !== e.cy) begin errors++; $display("[TB] FAIL main_carry: got %b want %b", m_carry, e.cy); end
            checks++;
            if (m_ovf !== e.ov) begin errors++; $display("[TB] FAIL main_overflow: got %b want %b", m_ovf, e.ov); end
            if (e.lat) begin
               checks++;
               if (cyc !== e.acc + 1) begin errors++; $display("[TB] FAIL main_latency: out at cycle %0d want %0d", cyc, e.acc + 1); end
            end
         end
      end
   end

   always @(negedge clk) begin : mon_w8s4
      exp_t e;
      #1;
      if (p8_out_valid && p8_out_ready) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("[TB] FAIL w8s4_unexpected: out=%h seen, required no beat", p8_out);
         end else begin
            e = q8.pop_front();
            if (p8_out !== e.res[7:0]) begin errors++; $display("[TB] FAIL w8s4_out: got %h want %h", p8_out, e.res[7:0]); end
            checks++;
            if (p8_carry !== e.cy) begin errors++; $display("[TB] FAIL w8s4_carry: got %b want %b", p8_carry, e.cy); end
            checks++;
            if (p8_ovf !== e.ov) begin errors++; $display("[TB] FAIL w8s4_overflow: got %b want %b", p8_ovf, e.ov); end
            if (e.lat) begin
               checks++;
               if (cyc !== e.acc + 3) begin errors++; $display("[TB] FAIL w8s4_latency: out at cycle %0d want %0d", cyc, e.acc + 3); end
            end
         end
      end
   end

   always @(negedge clk) begin : mon_w32s1
      exp_t e;
      #1;
      if (p1_out_valid && p1_out_ready) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("[TB] FAIL w32s1_unexpected: out=%h seen, required no beat", p1_out);
         end else begin
            e = q1.pop_front();
            if (p1_out !== e.res) begin errors++; $display("[TB] FAIL w32s1_out: got %h want %h", p1_out, e.res); end
            checks++;
            if (p1_carry !== e.cy) begin errors++; $display("[TB] FAIL w32s1_carry: got %b want %b", p1_carry, e.cy); end
            checks++;
            if (p1_ovf !== e.ov) begin errors++; $display("[TB] FAIL w32s1_overflow: got %b want %b", p1_ovf, e.ov); end
            if (e.lat) begin
               checks++;
               if (cyc !== e.acc) begin errors++; $display("[TB] FAIL w32s1_latency: out at cycle %0d want %0d", cyc, e.acc); end
            end
         end
      end
   end

   // Holds the beat until the unit takes it, then records the expected result.
   task automatic send_main(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input exp_t e);
      bit done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         m_in_valid = 1'b1;
         m_in1      = a;
         m_in2      = b;
         m_op       = op;
         #1;
         if (m_in_ready) begin
            e.acc = cyc + 1;
            q_m.push_back(e);
            done = 1'b1;
         end
      end
      checks++;
      if (!done) begin errors++; $display("[TB] FAIL main_accept: in_ready stayed 0, required a beat accepted"); end
   endtask

   task automatic idle_main();
      @(negedge clk);
      m_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_valid: got %b want 0", m_out_valid); end
      checks++; if (m_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_init_out: got %h want 0", m_out); end
      checks++; if (m_carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_carry: got %b want 0", m_carry); end
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_overflow: got %b want 0", m_ovf); end
      checks++; if (p8_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_w8s4: got %b want 0", p8_out_valid); end
      checks++; if (p1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_w32s1: got %b want 0", p1_out_valid); end
      @(negedge clk);
      reset_n     = 1'b1;
      m_out_ready = 1'b0;
      send_main(32'h8000_0000, 32'h8000_0001, 2'b00, mk(32'h0000_0001, 1'b1, 1'b1));
      send_main(32'h0000_0001, 32'h0000_0002, 2'b00, mk(32'h0000_0003, 1'b0, 1'b0));
      @(negedge clk);
      m_in_valid = 1'b0;
      #1;
      checks++; if (m_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL inflight_valid: got %b want 1", m_out_valid); end
      checks++; if (m_out !== 32'h1) begin errors++; $display("[TB] FAIL inflight_out: got %h want 00000001", m_out); end
      checks++; if (m_carry !== 1'b1) begin errors++; $display("[TB] FAIL inflight_carry: got %b want 1", m_carry); end
      checks++; if (m_ovf !== 1'b1) begin errors++; $display("[TB] FAIL inflight_overflow: got %b want 1", m_ovf); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid: got %b want 0", m_out_valid); end
      checks++; if (m_out !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_out: got %h want 0", m_out); end
      checks++; if (m_carry !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_carry: got %b want 0", m_carry); end
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_overflow: got %b want 0", m_ovf); end
      @(negedge clk);
      reset_n = 1'b1;
      q_m.delete();
      m_out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         checks++; if (m_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_beat: out_valid %b want 0", m_out_valid); end
         checks++; if (m_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b want 1", m_in_ready); end
      end
   endtask

   task automatic test_wrap_add();
      m_out_ready = 1'b1;
      send_main(32'h0000_FFFF, 32'h0000_0001, 2'b00, mk(32'h0001_0000, 1'b0, 1'b0));
      idle_main();
      for (int t = 0; t < 20 && q_m.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (q_m.size() != 0) begin errors++; $display("[TB] FAIL wrap_add_drain: %0d pending want 0", q_m.size()); end
   endtask

   task automatic test_sub_saturate();
      m_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send_main(sv_a[i], sv_b[i], sv_op[i], mk(sv_res[i], sv_cy[i], sv_ov[i]));
      idle_main();
      for (int t = 0; t < 30 && q_m.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (q_m.size() != 0) begin errors++; $display("[TB] FAIL sub_sat_drain: %0d pending want 0", q_m.size()); end
   endtask

   task automatic test_back_to_back();
      m_out_ready = 1'b0;
      fork
         begin
            logic [31:0] a, b;
            logic [1:0]  op;
            exp_t        e;
            for (int i = 0; i < 8; i++) begin
               a  = pick32();
               b  = pick32();
               op = 2'($urandom_range(0, 3));
               e  = ref_model(32, a, b, op);
               e.lat = 1'b0;
               send_main(a, b, op, e);
            end
            idle_main();
         end
         begin
            logic [31:0] held_out;
            logic        held_c, held_v;
            bit          seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               #1;
               seen = m_out_valid;
            end
            checks++; if (!seen) begin errors++; $display("[TB] FAIL stall_first_result: out_valid never rose, want out_valid 1"); end
            held_out = m_out;
            held_c   = m_carry;
            held_v   = m_ovf;
            checks++; if (m_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b want 0", m_in_ready); end
            repeat (2) begin
               @(negedge clk);
               #1;
               checks++; if (m_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %b want 1", m_out_valid); end
               checks++; if (m_out !== held_out) begin errors++; $display("[TB] FAIL stall_out_stable: got %h want %h", m_out, held_out); end
               checks++; if (m_carry !== held_c) begin errors++; $display("[TB] FAIL stall_carry_stable: got %b want %b", m_carry, held_c); end
               checks++; if (m_ovf !== held_v) begin errors++; $display("[TB] FAIL stall_ovf_stable: got %b want %b", m_ovf, held_v); end
               checks++; if (m_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b want 0", m_in_ready); end
            end
            @(negedge clk);
            m_out_ready = 1'b1;
         end
      join
      for (int t = 0; t < 60 && q_m.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (q_m.size() != 0) begin errors++; $display("[TB] FAIL backpressure_drain: %0d pending want 0", q_m.size()); end
   endtask

   task automatic test_param_w8s4();
      exp_t e;
      int   acc_n = 0;
      p8_out_ready = 1'b1;
      for (int t = 0; t < 4000 && acc_n < 1000; t++) begin
         @(negedge clk);
         p8_in_valid = ($urandom_range(0, 4) != 0);
         p8_in1      = pick8();
         p8_in2      = pick8();
         p8_op       = 2'($urandom_range(0, 3));
         #1;
         if (p8_in_valid && p8_in_ready) begin
            e = ref_model(8, {24'd0, p8_in1}, {24'd0, p8_in2}, p8_op);
            e.acc = cyc + 1;
            q8.push_back(e);
            acc_n++;
         end
      end
      @(negedge clk);
      p8_in_valid = 1'b0;
      for (int t = 0; t < 20 && q8.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (acc_n != 1000) begin errors++; $display("[TB] FAIL w8s4_accepted: %0d beats want 1000", acc_n); end
      checks++; if (q8.size() != 0) begin errors++; $display("[TB] FAIL w8s4_drain: %0d pending want 0", q8.size()); end
      acc_n = 0;
      for (int t = 0; t < 3000 && acc_n < 300; t++) begin
         @(negedge clk);
         p8_out_ready = ($urandom_range(0, 2) != 0);
         p8_in_valid  = ($urandom_range(0, 3) != 0);
         p8_in1       = pick8();
         p8_in2       = pick8();
         p8_op        = 2'($urandom_range(0, 3));
         #1;
         if (p8_in_valid && p8_in_ready) begin
            e = ref_model(8, {24'd0, p8_in1}, {24'd0, p8_in2}, p8_op);
            e.lat = 1'b0;
            q8.push_back(e);
            acc_n++;
         end
      end
      @(negedge clk);
      p8_in_valid  = 1'b0;
      p8_out_ready = 1'b1;
      for (int t = 0; t < 20 && q8.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (q8.size() != 0) begin errors++; $display("[TB] FAIL w8s4_bp_drain: %0d pending want 0", q8.size()); end
   endtask

   task automatic test_param_w32s1();
      exp_t e;
      int   acc_n = 0;
      p1_out_ready = 1'b1;
      for (int t = 0; t < 4000 && acc_n < 1000; t++) begin
         @(negedge clk);
         p1_in_valid = ($urandom_range(0, 4) != 0);
         p1_in1      = pick32();
         p1_in2      = pick32();
         p1_op       = 2'($urandom_range(0, 3));
         #1;
         if (p1_in_valid && p1_in_ready) begin
            e = ref_model(32, p1_in1, p1_in2, p1_op);
            e.acc = cyc + 1;
            q1.push_back(e);
            acc_n++;
         end
      end
      @(negedge clk);
      p1_in_valid = 1'b0;
      for (int t = 0; t < 20 && q1.size() != 0; t++) @(negedge clk);
      #2;
      checks++; if (acc_n != 1000) begin errors++; $display("[TB] FAIL w32s1_accepted: %0d beats want 1000", acc_n); end
      checks++; if (q1.size() != 0) begin errors++; $display("[TB] FAIL w32s1_drain: %0d pending want 0", q1.size()); end
   endtask

   initial begin
      reset_n      = 1'b0;
      m_in_valid   = 1'b0; m_in1 = '0; m_in2 = '0; m_op = '0; m_out_ready = 1'b1;
      p8_in_valid  = 1'b0; p8_in1 = '0; p8_in2 = '0; p8_op = '0; p8_out_ready = 1'b1;
      p1_in_valid  = 1'b0; p1_in1 = '0; p1_in2 = '0; p1_op = '0; p1_out_ready = 1'b1;
      test_reset();
      test_wrap_add();
      test_sub_saturate();
      test_back_to_back();
      test_param_w8s4();
      test_param_w32s1();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
